// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation-apply stage: gain-compensation
// constant, quadrant pre-rotation codes and the FSM state encoding.
package cordic_pkg;

  // 1/K for the CORDIC gain in Q8 (0.6055 * 256 ~= 155), applied as (v*155)>>>8.
  localparam int unsigned GAIN_Q8    = 155;
  localparam int unsigned GAIN_SHIFT = 8;

  // Pre-rotation codes handed over by the vectoring stage.
  localparam logic [1:0] QUAD_NONE  = 2'b00; // (x, y)
  localparam logic [1:0] QUAD_NEG90 = 2'b01; // (y, -x)
  localparam logic [1:0] QUAD_POS90 = 2'b10; // (-y, x)
  localparam logic [1:0] QUAD_180   = 2'b11; // (-x, -y)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ITER  = 2'b01,
    ST_SCALE = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

endpackage

// File: rtl/cordic_scale_sat.sv
// Gain compensation for one vector component: multiply by the Q8 gain,
// arithmetic shift right, then clamp into the signed output range.
module cordic_scale_sat
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = 18
) (
  input  logic signed [IN_WIDTH-1:0]   din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  // One extra bit beyond IN_WIDTH+GAIN_SHIFT keeps the product sign-safe.
  localparam int PW = IN_WIDTH + GAIN_SHIFT + 1;

  localparam logic signed [PW-1:0] GAIN_EXT = PW'(GAIN_Q8);
  localparam logic signed [PW-1:0] SAT_MAX  = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN  = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] din_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  assign din_ext = {{(PW-IN_WIDTH){din[IN_WIDTH-1]}}, din};

  // Scale by the gain constant and saturate instead of letting the result wrap.
  always_comb begin
    prod    = din_ext * GAIN_EXT;
    shifted = prod >>> GAIN_SHIFT;
    if (shifted > SAT_MAX) begin
      dout = OUT_MAX;
    end else if (shifted < SAT_MIN) begin
      dout = OUT_MIN;
    end else begin
      dout = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/cordic_rotation_apply.sv
// Applies a precomputed set of CORDIC micro-rotation decisions (plus a
// quadrant pre-rotation) to an input vector, one micro-rotation per cycle,
// then gain-compensates and holds the result until the consumer takes it.
module cordic_rotation_apply
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CORDIC_STEPS = 16
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic [CORDIC_STEPS-1:0]      micro_rotation,
  input  logic [1:0]                   quadrant,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         busy
);

  // Two guard bits: one for negating the most negative input, one for the
  // ~1.65x CORDIC growth.
  localparam int IW    = DATA_WIDTH + 2;
  localparam int CNT_W = (CORDIC_STEPS > 1) ? $clog2(CORDIC_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CORDIC_STEPS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CORDIC_STEPS-1:0] dir_q, dir_d;
  logic signed [IW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [DATA_WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;

  logic signed [IW-1:0]    x_ext, y_ext;
  logic signed [IW-1:0]    x_shift, y_shift;
  logic signed [DATA_WIDTH-1:0] x_scaled, y_scaled;
  logic                    accept;

  assign x_ext   = {{2{x_in[DATA_WIDTH-1]}}, x_in};
  assign y_ext   = {{2{y_in[DATA_WIDTH-1]}}, y_in};
  assign x_shift = x_q >>> cnt_q;
  assign y_shift = y_q >>> cnt_q;

  // Handshake/status outputs are forced low while reset is asserted.
  assign in_ready  = nreset && (state_q == ST_IDLE);
  assign busy      = nreset && (state_q != ST_IDLE);
  assign out_valid = nreset && (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;

  cordic_scale_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IW)
  ) u_scale_x (
    .din  (x_q),
    .dout (x_scaled)
  );

  cordic_scale_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IW)
  ) u_scale_y (
    .din  (y_q),
    .dout (y_scaled)
  );

  // Next-state and datapath: capture with pre-rotation, iterate, scale, hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ITER;
          cnt_d   = {CNT_W{1'b0}};
          dir_d   = micro_rotation;
          case (quadrant)
            QUAD_NONE: begin
              x_d = x_ext;
              y_d = y_ext;
            end
            QUAD_NEG90: begin
              x_d = y_ext;
              y_d = -x_ext;
            end
            QUAD_POS90: begin
              x_d = -y_ext;
              y_d = x_ext;
            end
            default: begin // QUAD_180
              x_d = -x_ext;
              y_d = -y_ext;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (dir_q[cnt_q]) begin
          x_d = x_q + y_shift;
          y_d = y_q - x_shift;
        end else begin
          x_d = x_q - y_shift;
          y_d = y_q + x_shift;
        end
        if (cnt_q == LAST_STEP) begin
          state_d = ST_SCALE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SCALE: begin
        x_out_d = x_scaled;
        y_out_d = y_scaled;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      dir_q   <= {CORDIC_STEPS{1'b0}};
      x_q     <= {IW{1'b0}};
      y_q     <= {IW{1'b0}};
      x_out_q <= {DATA_WIDTH{1'b0}};
      y_out_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

endmodule

// File: tb/tb_cordic_rotation_apply.sv
// Self-checking bench for cordic_rotation_apply: table-driven directed vectors,
// hand-written HOLD-stall and mid-iteration reset sequences, and random jobs,
// all compared against a plain-integer reference model.
module tb_cordic_rotation_apply;

  logic               clk = 1'b0;
  logic               nreset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in, y_in;
  logic [15:0]        micro_rotation;
  logic [1:0]         quadrant;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x_out, y_out;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int out_cnt = 0;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] mr;
    logic [1:0]  q;
    int          ex;
    int          ey;
  } vec_t;

  vec_t tbl[6];

  cordic_rotation_apply #(.DATA_WIDTH(16), .CORDIC_STEPS(16)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .x_in           (x_in),
    .y_in           (y_in),
    .micro_rotation (micro_rotation),
    .quadrant       (quadrant),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .x_out          (x_out),
    .y_out          (y_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Count accepted jobs and delivered results to catch lost/duplicated jobs.
  always @(posedge clk) begin
    if (nreset && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (nreset && out_valid && out_ready) out_cnt <= out_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  // Reference: quadrant swap/negate, then textbook CORDIC micro-rotations on
  // unbounded integers, then (v*155)>>>8 with clamp to 16 bits.
  task automatic model(input int x, input int y, input logic [15:0] mr,
                       input logic [1:0] q, output int ox, output int oy);
    int a, b, t;
    case (q)
      2'b00:   begin a = x;  b = y;  end
      2'b01:   begin a = y;  b = -x; end
      2'b10:   begin a = -y; b = x;  end
      default: begin a = -x; b = -y; end
    endcase
    for (int i = 0; i < 16; i++) begin
      if (mr[i]) begin
        t = a + (b >>> i); b = b - (a >>> i); a = t;
      end else begin
        t = a - (b >>> i); b = b + (a >>> i); a = t;
      end
    end
    ox = sat16((a * 155) >>> 8);
    oy = sat16((b * 155) >>> 8);
  endtask

  // Vectoring decisions: drive y toward zero, bit=1 when y is non-negative.
  function automatic logic [15:0] vec_bits(input int x, input int y);
    logic [15:0] r;
    int a, b, t;
    a = x; b = y; r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (b >= 0) begin
        r[i] = 1'b1; t = a + (b >>> i); b = b - (a >>> i); a = t;
      end else begin
        r[i] = 1'b0; t = a - (b >>> i); b = b + (a >>> i); a = t;
      end
    end
    return r;
  endfunction

  task automatic junk_inputs();
    in_valid       = 1'($urandom_range(0, 1));
    x_in           = 16'($urandom);
    y_in           = 16'($urandom);
    micro_rotation = 16'($urandom);
    quadrant       = 2'($urandom_range(0, 3));
  endtask

  // Full job: wait for in_ready, present the job, count edges to out_valid,
  // optionally stall in HOLD checking stability, then release.
  task automatic run_job(input int x, input int y, input logic [15:0] mr,
                         input logic [1:0] q, input int stall,
                         output int rx, output int ry);
    int guard;
    int lat;
    rx = 0; ry = 0; guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1; x_in = x[15:0]; y_in = y[15:0];
    micro_rotation = mr; quadrant = q;
    @(posedge clk);
    lat = 1;
    #1;
    junk_inputs();
    out_ready = 1'($urandom_range(0, 1));
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (!out_valid) begin
        junk_inputs();
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    out_ready = 1'b0;
    check("latency", lat, 18);
    if (!out_valid) return;
    rx = x_out; ry = y_out;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_x", x_out, rx);
      check("hold_y", y_out, ry);
      check("hold_in_ready", in_ready, 0);
      junk_inputs();
    end
    out_ready = 1'b1;
    #1;
    check("in_ready_release_cycle", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  initial begin
    int rx, ry, ex, ey, a0, o0, x, y, s;
    logic [15:0] mr;
    logic [1:0] q;

    nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = 16'sd0; y_in = 16'sd0; micro_rotation = 16'h0000; quadrant = 2'b00;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", in_ready, 1);

    // Directed table
    tbl[0] = '{x: 3000,   y: 4000,  mr: vec_bits(3000, 4000),   q: 2'b00, ex: 0, ey: 0};
    tbl[1] = '{x: 1000,   y: 0,     mr: 16'hAAAA,               q: 2'b10, ex: 0, ey: 0};
    tbl[2] = '{x: -32768, y: 0,     mr: vec_bits(32767, 0),     q: 2'b11, ex: 0, ey: 0};
    tbl[3] = '{x: 32767,  y: 32767, mr: vec_bits(32767, 32767), q: 2'b00, ex: 0, ey: 0};
    tbl[4] = '{x: 32767,  y: 32767, mr: vec_bits(32767, 32767), q: 2'b11, ex: 0, ey: 0};
    tbl[5] = '{x: -1234,  y: 567,   mr: 16'h5A3C,               q: 2'b01, ex: 0, ey: 0};
    for (int i = 0; i < 6; i++) begin
      model(tbl[i].x, tbl[i].y, tbl[i].mr, tbl[i].q, ex, ey);
      tbl[i].ex = ex;
      tbl[i].ey = ey;
    end
    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].x, tbl[i].y, tbl[i].mr, tbl[i].q, i % 3, rx, ry);
      check("tbl_x", rx, tbl[i].ex);
      check("tbl_y", ry, tbl[i].ey);
      if (i == 0) begin
        check("mag_3_4_5_x", int'(rx >= 4977 && rx <= 4993), 1);
        check("mag_3_4_5_y", int'(ry >= -8 && ry <= 8), 1);
      end
      if (i == 2) check("neg_full_no_wrap", int'(rx > 0), 1);
      if (i == 3) check("sat_pos", rx, 32767);
      if (i == 4) check("sat_neg", rx, -32768);
    end

    // Long HOLD stall with out_ready low for 20 cycles
    run_job(-20000, 15000, 16'h3C5A, 2'b10, 20, rx, ry);
    model(-20000, 15000, 16'h3C5A, 2'b10, ex, ey);
    check("stall_x", rx, ex);
    check("stall_y", ry, ey);

    // Reset during ITER step 7 aborts the job
    @(negedge clk);
    in_valid = 1'b1; x_in = 16'sd5000; y_in = -16'sd7000;
    micro_rotation = 16'h1234; quadrant = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy_mid_iter", busy, 1);
    nreset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_x_out", x_out, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready_after", in_ready, 1);
    s = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) s++;
    end
    check("abort_no_output", s, 0);
    run_job(5000, -7000, 16'h1234, 2'b00, 1, rx, ry);
    model(5000, -7000, 16'h1234, 2'b00, ex, ey);
    check("post_abort_x", rx, ex);
    check("post_abort_y", ry, ey);

    // Random back-to-back jobs with random HOLD stalls
    a0 = acc_cnt;
    o0 = out_cnt;
    for (int j = 0; j < 50; j++) begin
      x  = int'($urandom_range(0, 65535)) - 32768;
      y  = int'($urandom_range(0, 65535)) - 32768;
      mr = 16'($urandom);
      q  = 2'($urandom_range(0, 3));
      s  = int'($urandom_range(0, 3));
      run_job(x, y, mr, q, s, rx, ry);
      model(x, y, mr, q, ex, ey);
      check("rand_x", rx, ex);
      check("rand_y", ry, ey);
    end
    @(negedge clk);
    check("accept_count", acc_cnt - a0, 50);
    check("output_count", out_cnt - o0, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_rotation_apply.md
CORDIC_ROTATION_APPLY -- requirements
Module: cordic_rotation_apply

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed width of the vector datapath ports.
REQ-002 Parameter CORDIC_STEPS, default 16, number of micro-rotations applied, which is also the micro_rotation width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 nreset  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  the job on x_in/y_in/micro_rotation/quadrant is valid.
REQ-006 in_ready  output  1  block accepts a job; high only in IDLE.
REQ-007 x_in, y_in  input  DATA_WIDTH each  signed vector to rotate.
REQ-008 micro_rotation  input  CORDIC_STEPS  direction bits produced by the vectoring stage; bit i is the decision for step i.
REQ-009 quadrant  input  2  pre-rotation code produced by the vectoring stage.
REQ-010 out_valid  output  1  x_out/y_out hold a valid result.
REQ-011 out_ready  input  1  the consumer takes the result.
REQ-012 x_out, y_out  output  DATA_WIDTH each  signed rotated, gain-compensated vector.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL capture x_in, y_in, micro_rotation and quadrant on the rising edge where in_valid && in_ready, then enter ITER with step counter = 0.
REQ-015 Pre-rotation SHALL be applied at capture: 00 gives (x,y); 01 gives (y,-x); 10 gives (-y,x); 11 gives (-x,-y).
REQ-016 Internal x/y registers SHALL be DATA_WIDTH+2 bits and sign-extended, so that -2^(DATA_WIDTH-1) negation and CORDIC growth never wrap.
REQ-017 ITER step i:
- bit i = 1: x' = x + (y>>>i), y' = y - (x>>>i).
- bit i = 0: x' = x - (y>>>i), y' = y + (x>>>i).
- Shifts are arithmetic; one step is performed per cycle.
REQ-018 After step CORDIC_STEPS-1 the FSM SHALL go to SCALE.
REQ-019 SCALE SHALL multiply each component by the constant 155 (Q8 form of 0.6055), arithmetic-shift right by 8, and saturate to the DATA_WIDTH signed range.
REQ-020 SCALE SHALL then go to HOLD with out_valid = 1.
REQ-021 FSM states SHALL be exactly IDLE, ITER, SCALE, HOLD.
REQ-022 FSM transitions SHALL be:
- IDLE to ITER on accept.
- ITER to SCALE when counter = CORDIC_STEPS-1.
- SCALE to HOLD.
- HOLD to IDLE on out_ready.
REQ-023 Latency SHALL be exactly CORDIC_STEPS+2 rising edges from the accept edge to out_valid first high (18 at default).
REQ-024 x_out, y_out and out_valid SHALL stay stable in HOLD until out_ready is sampled high.
REQ-025 in_ready SHALL be 0 in the HOLD cycle where out_ready is high; the next accept is possible no earlier than one cycle later.
REQ-026 in_valid SHALL be ignored outside IDLE, and input changes during ITER/SCALE/HOLD SHALL NOT affect the result.
REQ-027 out_ready SHALL be ignored outside HOLD.
REQ-028 The block SHALL be throughput-limited to one job per CORDIC_STEPS+3 cycles; there is no input buffering.

Reset
REQ-029 While nreset is low at a rising edge, the FSM SHALL go to IDLE and counter, x/y registers, x_out and y_out SHALL clear to 0.
REQ-030 While nreset is low, out_valid = 0, busy = 0 and in_ready = 0.
REQ-031 Reset in any state, including mid-ITER, SHALL abort the job with no output.
REQ-032 in_ready SHALL be 1 on the first edge after nreset returns high.

Structure
REQ-033 Shared package cordic_pkg SHALL hold:
- the gain constant 155 and its shift of 8;
- the quadrant code localparams;
- the FSM state encoding.
REQ-034 One sub-module, cordic_scale_sat, SHALL implement the multiply, shift and saturate, instantiated once per component.

Verification
REQ-035 Send x=3000, y=4000, quadrant=00, micro_rotation from the bench vectoring model of (3000,4000) -> x_out = 4985±8, y_out = 0±8, out_valid on edge 18 after accept.
REQ-036 Send x=1000, y=0, quadrant=10, micro_rotation=16'hAAAA -> result matches the bit-accurate bench model exactly.
REQ-037 Send x=-32768, y=0, quadrant=11, micro_rotation = vectoring bits of (32767,0) -> x_out saturates to 32767 or lies within the model value; no wrap to negative.
REQ-038 Hold out_ready low for 20 cycles in HOLD -> x_out/y_out/out_valid stay constant and in_ready stays 0; raise out_ready -> out_valid drops next edge and in_ready rises.
REQ-039 Pull nreset low during ITER step 7 -> out_valid never rises and in_ready = 1 after release; the next job gives a correct result.
REQ-040 Send 50 random back-to-back jobs with random out_ready stalls -> every output equals the model and no job is lost or duplicated.
